// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multi-digit seven-segment display block:
// active-low segment patterns, controller state type and a helper that
// computes the largest value representable in n decimal digits.
package seven_seg_pkg;

  // Controller states. The encoding is fixed so that external checkers can
  // decode the debug state output without importing this package.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // 10^n - 1, evaluated at elaboration. Valid for n up to 19 digits.
  function automatic logic [63:0] max_value(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder.
// A blank request or any non-BCD code (10..15) turns all segments off.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup with blank as the safe default.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_DIGIT[0];
        4'd1:    seg = SEG_DIGIT[1];
        4'd2:    seg = SEG_DIGIT[2];
        4'd3:    seg = SEG_DIGIT[3];
        4'd4:    seg = SEG_DIGIT[4];
        4'd5:    seg = SEG_DIGIT[5];
        4'd6:    seg = SEG_DIGIT[6];
        4'd7:    seg = SEG_DIGIT[7];
        4'd8:    seg = SEG_DIGIT[8];
        4'd9:    seg = SEG_DIGIT[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_display.sv
// Multi-digit seven-segment display driver.
// Accepts an unsigned binary value, converts it to NUM_DIGITS BCD digits
// with a sequential double-dabble engine (one shift per clock) and drives
// NUM_DIGITS active-low seven-segment patterns. Values above
// 10^NUM_DIGITS-1 are flagged on ovf_o and shown as dashes.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   - digits above the most significant non-zero digit are blank
//               (digit 0 is always shown); bcd_o is unaffected.
//   undefined - every digit shows its decoded value, leading zeros included.
//
// Handshake: a value is accepted on a rising edge where valid_i && ready_o.
// ready_o is high only in IDLE; valid_i while ready_o is low is ignored and
// nothing is queued. done_o pulses for one cycle when the outputs update;
// the block is back in IDLE during that cycle, so the next value can be
// accepted on the edge that ends the done_o cycle.
module seven_seg_display
  import seven_seg_pkg::*;
#(
  parameter int WIDTH      = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        value_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    ovf_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic [7*NUM_DIGITS-1:0] segments_o,
  output state_t                  state_o
);

  localparam int          AW      = 4 * NUM_DIGITS;
  localparam int          SW      = 7 * NUM_DIGITS;
  localparam int          CW      = $clog2(WIDTH + 1);
  localparam logic [63:0] MAX_VAL = max_value(NUM_DIGITS);

  state_t                  state;
  logic [WIDTH-1:0]        sr;        // binary bits still to be shifted in
  logic [AW-1:0]           acc;       // BCD accumulator
  logic [CW-1:0]           cnt;       // shifts remaining
  logic                    ovf_pend;  // overflow decision taken at capture
  logic                    value_ovf;
  logic [AW-1:0]           acc_adj;
  logic [AW+WIDTH-1:0]     shifted;
  logic [NUM_DIGITS-1:0]   blank;
  logic [SW-1:0]           seg_dec;

  assign ready_o = (state == IDLE);
  assign state_o = state;

  // Overflow check; stays false when WIDTH cannot exceed the limit.
  assign value_ovf = (64'(value_i) > MAX_VAL);

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  always_comb begin
    acc_adj = acc;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (acc[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
      end
    end
  end

  // One combined left shift; the carry out of the top digit is dropped.
  assign shifted = {acc_adj, sr} << 1;

  // Leading-zero blanking mask (all zeros when the feature is disabled).
  always_comb begin
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    blank[NUM_DIGITS-1] = (acc[AW-1 -: 4] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 1; k--) begin
      blank[k] = blank[k+1] && (acc[4*k +: 4] == 4'd0);
    end
    blank[0] = 1'b0;
`endif
  end

  // One decoder per digit, fed from the final accumulator.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    bcd_to_seg u_dec (
      .bcd   (acc[4*k +: 4]),
      .blank (blank[k]),
      .seg   (seg_dec[7*k +: 7])
    );
  end

  // Controller and conversion engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            sr       <= value_i;
            acc      <= '0;
            cnt      <= CW'(WIDTH);
            ovf_pend <= value_ovf;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          acc <= shifted[AW+WIDTH-1:WIDTH];
          sr  <= shifted[WIDTH-1:0];
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Visible outputs change only in UPDATE; they hold during conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_o     <= 1'b0;
      ovf_o      <= 1'b0;
      bcd_o      <= '0;
      segments_o <= '1;
    end else if (state == UPDATE) begin
      done_o <= 1'b1;
      if (ovf_pend) begin
        ovf_o      <= 1'b1;
        bcd_o      <= '1;
        segments_o <= {NUM_DIGITS{SEG_DASH}};
      end else begin
        ovf_o      <= 1'b0;
        bcd_o      <= acc;
        segments_o <= seg_dec;
      end
    end else begin
      done_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seven_seg_display.sv
// Bench for seven_seg_display at default parameters.
module tb_seven_seg_display;

  localparam int WIDTH      = 14;
  localparam int NUM_DIGITS = 4;
  localparam int AW         = 4 * NUM_DIGITS;
  localparam int SW         = 7 * NUM_DIGITS;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] value_i;
  logic             valid_i;
  logic             ready_o;
  logic             done_o;
  logic             ovf_o;
  logic [AW-1:0]    bcd_o;
  logic [SW-1:0]    segments_o;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_bcd_q[$];
  logic [SW-1:0] exp_seg_q[$];
  logic          exp_ovf_q[$];
  logic [AW-1:0] prev_bcd;

  seven_seg_display #(.WIDTH(WIDTH), .NUM_DIGITS(NUM_DIGITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_i    (value_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .ovf_o      (ovf_o),
    .bcd_o      (bcd_o),
    .segments_o (segments_o),
    .state_o    (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic push_expected(input int v);
    int            lim;
    int            t;
    int            msd;
    int            d [NUM_DIGITS];
    logic [AW-1:0] b;
    logic [SW-1:0] s;
    logic          o;
    lim = 1;
    for (int k = 0; k < NUM_DIGITS; k++) lim = lim * 10;
    o   = (v >= lim);
    t   = v;
    msd = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      d[k] = t % 10;
      t    = t / 10;
      if (d[k] != 0) msd = k;
    end
    if (o) begin
      b = '1;
      for (int k = 0; k < NUM_DIGITS; k++) s[7*k +: 7] = 7'b0111111;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        b[4*k +: 4] = 4'(d[k]);
        s[7*k +: 7] = seg_of(d[k]);
`ifdef LEADING_ZERO_BLANK_EN
        if (k > msd) s[7*k +: 7] = 7'b1111111;
`endif
      end
    end
    exp_bcd_q.push_back(b);
    exp_seg_q.push_back(s);
    exp_ovf_q.push_back(o);
  endtask

  // ---------------- driver tasks ----------------
  // Waits for ready, presents v for one cycle; returns at the negedge
  // following the acceptance edge.
  task automatic send_pulse(input int v);
    int guard;
    guard = 0;
    while (ready_o !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: ready_o=%b required 1 within 100 cycles", ready_o);
    end
    value_i = WIDTH'(v);
    valid_i = 1'b1;
    push_expected(v);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Called at the negedge right after an acceptance edge. Checks latency,
  // output hold, the popped expectation and the one-cycle done pulse.
  task automatic wait_result(input string name);
    int            cyc;
    int            low;
    bit            hold_ok;
    logic [AW-1:0] eb;
    logic [SW-1:0] es;
    logic          eo;
    cyc     = 1;
    low     = 0;
    hold_ok = 1'b1;
    while (done_o !== 1'b1 && cyc < 100) begin
      if (ready_o === 1'b0) low++;
      if (bcd_o !== prev_bcd) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done_o=%b required 1 within 100 cycles", name, done_o);
      return;
    end
    checks++;
    if (low !== WIDTH + 1) begin
      errors++;
      $display("FAIL %s_latency: ready_o low for %0d cycles, required %0d", name, low, WIDTH + 1);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL %s_hold: bcd_o changed during conversion, required %h", name, prev_bcd);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_at_done: ready_o=%b required 1", name, ready_o);
    end
    checks++;
    if (exp_bcd_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected_done: got done_o with empty expected queue, required none", name);
    end else begin
      eb = exp_bcd_q.pop_front();
      es = exp_seg_q.pop_front();
      eo = exp_ovf_q.pop_front();
      if (bcd_o !== eb) begin
        errors++;
        $display("FAIL %s_bcd: got %h required %h", name, bcd_o, eb);
      end
      checks++;
      if (segments_o !== es) begin
        errors++;
        $display("FAIL %s_segments: got %b required %b", name, segments_o, es);
      end
      checks++;
      if (ovf_o !== eo) begin
        errors++;
        $display("FAIL %s_ovf: got %b required %b", name, ovf_o, eo);
      end
      prev_bcd = eb;
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: done_o=%b required 0 one cycle later", name, done_o);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (segments_o !== '1) begin
      errors++;
      $display("FAIL reset_segments: got %b required all ones", segments_o);
    end
    checks++;
    if (bcd_o !== '0) begin
      errors++;
      $display("FAIL reset_bcd: got %h required 0", bcd_o);
    end
    checks++;
    if (ovf_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got ovf=%b done=%b required 0 0", ovf_o, done_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", ready_o);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d required 0", state_dbg);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    send_pulse(1234);
    wait_result("v1234");
  endtask

  task automatic test_digits();
    send_pulse(7);
    wait_result("v7");
    send_pulse(0);
    wait_result("v0");
    send_pulse(50);
    wait_result("v50");
    send_pulse(905);
    wait_result("v905");
  endtask

  task automatic test_overflow();
    send_pulse(10000);
    wait_result("v10000");
    send_pulse(16383);
    wait_result("v16383");
    send_pulse(9999);
    wait_result("v9999");
  endtask

  // valid_i stays high; the value change during conversion must be ignored
  // and the second value accepted on the edge ending the done_o cycle.
  task automatic test_back_to_back();
    int guard;
    guard = 0;
    while (ready_o !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    value_i = WIDTH'(42);
    valid_i = 1'b1;
    push_expected(42);
    @(negedge clk);
    value_i = WIDTH'(99);
    wait_result("v42");
    push_expected(99);
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: ready_o=%b required 0 in cycle after done_o", ready_o);
    end
    valid_i = 1'b0;
    wait_result("v99");
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    send_pulse(1234);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (segments_o !== '1 || bcd_o !== '0 || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got seg=%b bcd=%h ovf=%b required all ones, 0, 0",
               segments_o, bcd_o, ovf_o);
    end
    checks++;
    if (ready_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_handshake: got ready=%b done=%b required 1 0", ready_o, done_o);
    end
    exp_bcd_q.delete();
    exp_seg_q.delete();
    exp_ovf_q.delete();
    prev_bcd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midreset_no_done: got done_o=1 after aborted conversion, required 0");
    end
    send_pulse(5678);
    wait_result("v5678");
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 6; i++) begin
      v = $urandom_range(0, 16383);
      send_pulse(v);
      wait_result("random");
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n    = 1'b1;
    valid_i  = 1'b0;
    value_i  = '0;
    prev_bcd = '0;
    test_reset();
    test_basic();
    test_digits();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_bcd_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d results outstanding, required 0", exp_bcd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_display.md
Name: seven_seg_display

Overview:
- Multi-digit successor to the single-digit BCD decoder.
- Accepts an unsigned binary value over a valid/ready handshake and converts it to NUM_DIGITS BCD digits with a sequential double-dabble engine (one shift per clock).
- Drives NUM_DIGITS active-low 7-segment patterns, for example the board HEX displays.
- Adds overflow indication; the optional feature adds leading-zero blanking.

Parameters:
- WIDTH, 14, bit width of the binary input value.
- NUM_DIGITS, 4, number of BCD digits and 7-segment displays driven.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- value_i  input  WIDTH  unsigned binary value to display.
- valid_i  input  1  value_i is valid this cycle.
- ready_o  output  1  block can accept a new value.
- done_o  output  1  one-cycle pulse when the outputs update.
- ovf_o  output  1  registered; last accepted value exceeded 10^NUM_DIGITS-1.
- bcd_o  output  4*NUM_DIGITS  registered BCD result; digit 0 in bits [3:0].
- segments_o  output  7*NUM_DIGITS  registered active-low segments; digit k in bits [7k+6:7k], bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, ready_o=1, done_o=0, ovf_o=0.
  - bcd_o all zero.
  - segments_o all 1 (blank).
  - Reset mid-conversion aborts the conversion and discards the work.
- Segment patterns (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, dash=0111111
- State machine: IDLE -> CONVERT -> UPDATE -> IDLE.
- IDLE:
  - ready_o=1.
  - On valid_i && ready_o at edge E0: capture value_i into a shift register, clear the BCD accumulator, load bit counter = WIDTH, go to CONVERT.
  - ready_o=0 from E0.
- CONVERT, one step per edge E1..E_WIDTH:
  - For every accumulator digit >= 5, add 3.
  - Then shift {accumulator, shift register} left by 1.
  - Decrement the counter; after the WIDTH-th shift, go to UPDATE.
  - The accumulator is 4*NUM_DIGITS bits; carry out of the top digit is discarded (overflow is handled separately).
- UPDATE, edge E_(WIDTH+1):
  - Register bcd_o, segments_o and ovf_o.
  - done_o=1 for exactly this one cycle; return to IDLE; ready_o=1 again.
  - Latency from acceptance to visible output is WIDTH+1 clocks (15 at defaults).
- Overflow:
  - Evaluated at capture as value_i > 10^NUM_DIGITS-1; the constant is computed at elaboration.
  - If the condition is impossible for the parameters, ovf_o stays 0.
  - On overflow, UPDATE sets ovf_o=1, bcd_o all 4'hF and every digit to dash.
  - Otherwise ovf_o=0.
- Outputs hold the previous result throughout CONVERT; no intermediate values are shown.
- valid_i while ready_o=0 is ignored; no queueing.
- Back-to-back: a new value may be accepted on the first cycle after done_o (IDLE).

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - In UPDATE (non-overflow), digits above the most significant non-zero digit show blank.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - bcd_o is unaffected.
- Undefined: every digit shows its decoded value, including leading zeros.

Decomposition:
- Package seven_seg_pkg:
  - Segment pattern constants SEG_DIGIT[0..9], SEG_BLANK, SEG_DASH.
  - State enum type (IDLE, CONVERT, UPDATE).
  - Function computing 10^n-1.
- Sub-module bcd_to_seg:
  - Combinational 4-bit BCD to 7-bit active-low decoder with a blank input.
  - Non-BCD codes produce blank.
  - Instantiated NUM_DIGITS times in a generate loop.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> segments_o=all 1, bcd_o=0, ovf_o=0, ready_o=1, done_o=0 immediately.
- Value 1234, single valid pulse -> ready_o low 15 cycles; done_o one cycle; bcd_o=16'h1234; segments digit3..0 = 1111001, 0100100, 0110000, 0011001; ovf_o=0.
- Value 7 -> with LEADING_ZERO_BLANK_EN: digit0=1111000, digits1-3=1111111. Without: digits1-3=1000000. Value 0 with the macro: digit0=1000000.
- Value 10000 (and 16383) -> ovf_o=1; bcd_o=16'hFFFF; all digits 0111111. A following value 9999 clears ovf_o and shows 0010000 x4.
- Hold valid_i high with value 42, then change to 99 during CONVERT -> 99 is ignored; result 42; next acceptance occurs in the cycle after done_o; second result 99.
- Pulse rst_n low at cycle 5 of a conversion of 1234 -> outputs blank, no done_o, ready_o=1; next value 5678 converts correctly.
